// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared definitions for the approximate multiplier pipeline.
//   MODE_EXACT / MODE_APPROX : encoding of the per-transaction mode bit
//   trunc_col(width)         : lowest partial-product column kept in approx mode
//   lowrows_sum(...)         : sum of the truncatable low-row partial products
package approx_mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;
    localparam int   MAX_W       = 32;

    function automatic int trunc_col(input int width);
        return width - 1;
    endfunction

    // Rows r < k of the multiplier contribute (y << r) when x_low[r] is set.
    // In approx mode every bit that lands below column trunc_col(width) is
    // dropped before summation, so the kept bits are summed exactly.
    function automatic logic [2*MAX_W-1:0] lowrows_sum(
        input logic [MAX_W-1:0] y,
        input logic [MAX_W-1:0] x_low,
        input int               k,
        input int               width,
        input logic             mode
    );
        logic [2*MAX_W-1:0] acc;
        logic [2*MAX_W-1:0] row;
        logic [2*MAX_W-1:0] keep;
        acc  = '0;
        keep = ~((64'd1 << trunc_col(width)) - 64'd1);
        for (int r = 0; r < MAX_W; r++) begin
            if (r < k && x_low[r]) begin
                row = 64'(y) << r;
                if (mode == MODE_APPROX) row = row & keep;
                acc = acc + row;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_lowrows.sv
// approx_pp_lowrows: combinational generator and summer of the low K
// partial-product rows, with truncation applied in approximate mode.
//   y     in  WIDTH    multiplicand
//   x_low in  K        low multiplier bits x[K-1:0]
//   mode  in  1        0 = exact, 1 = approximate
//   low   out 2*WIDTH  sum of the retained low-row bits
module approx_pp_lowrows
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 2
) (
    input  logic [WIDTH-1:0]   y,
    input  logic [K-1:0]       x_low,
    input  logic               mode,
    output logic [2*WIDTH-1:0] low
);

    assign low = (2*WIDTH)'(lowrows_sum(32'(y), 32'(x_low), K, WIDTH, mode));

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: elastic valid/ready pipelined unsigned multiplier with a
// per-transaction exact/approximate mode and a tag passthrough.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_x, in_y, in_mode, in_tag payload
//   out_valid/out_ready output handshake; out_z, out_mode, out_tag payload
//   approx_cnt          saturating count of delivered approximate results
// Stage 1 holds the high product and low-row sum, stage 2 the final sum,
// later stages only delay.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_ROWS = 2,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_z,
    output logic                 out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic [15:0]          approx_cnt
);

    localparam int ZW = 2 * WIDTH;
    localparam int LS = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] ld;
    logic [PIPE_STAGES-1:0] md;
    logic [TAG_W-1:0]       tg [PIPE_STAGES];
    logic [ZW-1:0]          s1_hi;
    logic [ZW-1:0]          s1_low;
    logic [ZW-1:0]          pz [1:LS];
    logic [ZW-1:0]          hi_c;
    logic [ZW-1:0]          low_c;
    logic [15:0]            cnt;

    assign hi_c = (ZW'(in_y) * ZW'(in_x[WIDTH-1:APPROX_ROWS])) << APPROX_ROWS;

    approx_pp_lowrows #(
        .WIDTH (WIDTH),
        .K     (APPROX_ROWS)
    ) u_lowrows (
        .y     (in_y),
        .x_low (in_x[APPROX_ROWS-1:0]),
        .mode  (in_mode),
        .low   (low_c)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    // The ready chain is walked from the output back toward the input.
    always_comb begin
        logic rdy;
        ld  = '0;
        rdy = out_ready;
        for (int k = LS; k >= 0; k--) begin
            ld[k] = !vld[k] || rdy;
            rdy   = ld[k];
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld    <= '0;
            md     <= '0;
            s1_hi  <= '0;
            s1_low <= '0;
            cnt    <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) tg[k] <= '0;
            for (int k = 1; k <= LS; k++) pz[k] <= '0;
        end else begin
            if (ld[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    s1_hi  <= hi_c;
                    s1_low <= low_c;
                    md[0]  <= in_mode;
                    tg[0]  <= in_tag;
                end
            end
            if (ld[1]) begin
                vld[1] <= vld[0];
                if (vld[0]) begin
                    pz[1] <= s1_hi + s1_low;
                    md[1] <= md[0];
                    tg[1] <= tg[0];
                end
            end
            for (int k = 2; k <= LS; k++) begin
                if (ld[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        pz[k] <= pz[k-1];
                        md[k] <= md[k-1];
                        tg[k] <= tg[k-1];
                    end
                end
            end
            if (vld[LS] && out_ready && md[LS] == MODE_APPROX && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
    end

    assign out_valid  = vld[LS];
    assign out_z      = pz[LS];
    assign out_mode   = md[LS];
    assign out_tag    = tg[LS];
    assign approx_cnt = cnt;

endmodule
